// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and data access. Each access is issued for one cycle, waits MEM_LAT cycles
// for read data, then acknowledges the owner with a one-cycle pulse. Data
// requests win over fetch because the MEM-stage instruction is older.
//
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive data
// grants made while fetch was waiting, the next IDLE grant goes to fetch.
//
// Handshake: if_req/dm_req are levels held by the requester until its
// ack; a request is sampled only in IDLE, and an ack pulses for exactly one
// cycle in RESP. mem_en is a one-cycle issue strobe; mem_rdata is taken
// MEM_LAT cycles after it.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic        dm_byte,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic        mem_byte,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [3:0] LAT_LD = 4'(MEM_LAT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;     // 1 = data port owns the access
  logic        mem_we_q, mem_we_d;
  logic        mem_byte_q, mem_byte_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  logic        idle_ok;
  logic        grant_dm;
  logic        grant_if;
  logic        force_if;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0]  starve_q, starve_d;

  // Fetch is forced once data has won STARVE_MAX times in a row over it.
  assign force_if = if_req && (starve_q == 4'(STARVE_MAX));

  // Saturating count of data grants made while fetch was waiting.
  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = 4'd0;
    end else if (grant_dm && if_req && (starve_q != 4'(STARVE_MAX))) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Starve counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Grants are only possible in IDLE and never while reset is asserted,
  // so every output reads zero during reset.
  assign idle_ok  = (state_q == S_IDLE) && rst_n;
  assign grant_dm = idle_ok && dm_req && !force_if;
  assign grant_if = idle_ok && if_req && !grant_dm;

  // Next-state logic: issue in IDLE, count down in WAIT, ack in RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_byte_d  = mem_byte_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_dm) begin
          owner_d     = 1'b1;
          mem_we_d    = dm_we;
          mem_byte_d  = dm_byte;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          cnt_d       = LAT_LD;
          state_d     = S_WAIT;
        end else if (grant_if) begin
          owner_d     = 1'b0;
          mem_we_d    = 1'b0;
          mem_byte_d  = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = 32'd0;
          cnt_d       = LAT_LD;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // Counter holds MEM_LAT in the first WAIT cycle, so the value 1
        // marks the cycle in which mem_rdata is valid.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
          if (owner_q) begin
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end else begin
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_byte_q  <= mem_byte_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // The _d values equal the issued values in the grant cycle and the held
  // values otherwise, so they drive the memory port directly.
  assign mem_en    = grant_dm || grant_if;
  assign mem_we    = mem_we_d;
  assign mem_byte  = mem_byte_d;
  assign mem_addr  = mem_addr_d;
  assign mem_wdata = mem_wdata_d;

  assign if_ack    = (state_q == S_RESP) && !owner_q;
  assign dm_ack    = (state_q == S_RESP) && owner_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  // Pipeline hold drops in the ack cycle so the pipeline advances on it.
  assign stall = rst_n && ((if_req && !if_ack) || (dm_req && !dm_ack));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner
// sequences and a randomized run checked by a transaction-timeline model.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic        dm_byte;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_en;
  logic        mem_we;
  logic        mem_byte;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  mem_port_arbiter #(
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_byte  (dm_byte),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_byte (mem_byte),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall    (stall)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2002_0004;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  // Returns mem_word(addr) exactly MEM_LAT cycles after the issue cycle and
  // junk in every other cycle, so a mistimed capture is visible.
  typedef struct {
    int          t;
    logic [31:0] a;
  } iss_t;
  iss_t iss_q[$];

  always @(negedge clk) begin
    if (!rst_n) iss_q.delete();
    else if (mem_en) iss_q.push_back('{cyc, mem_addr});
  end

  always @(posedge clk) begin
    #2;
    if (iss_q.size() > 0 && iss_q[0].t + MEM_LAT == cyc) begin
      mem_rdata = mem_word(iss_q[0].a);
      void'(iss_q.pop_front());
    end else begin
      mem_rdata = {16'hBAD0, cyc[15:0]};
    end
  end

  // ---------------- reference model / scoreboard ----------------
  // Timeline model: a grant at cycle T occupies the port until its ack at
  // T+MEM_LAT+1; the port is free again the cycle after the ack.
  logic        m_busy    = 1'b0;
  int          m_ack_cyc = 0;
  logic        m_dm      = 1'b0;
  logic        m_we      = 1'b0;
  logic        m_byte    = 1'b0;
  logic [31:0] m_addr    = '0;
  logic [31:0] m_wdata   = '0;
  logic [31:0] m_if_rd   = '0;
  logic [31:0] m_dm_rd   = '0;
  int          m_starve  = 0;
  logic        if_ack_last = 1'b0;
  logic        dm_ack_last = 1'b0;
  logic [31:0] exp_q[$];   // expected ack data, in grant order

  always @(negedge clk) begin
    logic e_en, e_ia, e_da, e_stall, g_dm, g_if;
    e_en = 1'b0; e_ia = 1'b0; e_da = 1'b0; e_stall = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0; m_we = 1'b0; m_byte = 1'b0; m_addr = '0; m_wdata = '0;
      m_if_rd = '0; m_dm_rd = '0; m_starve = 0;
      exp_q.delete();
    end else begin
      if (m_busy && cyc == m_ack_cyc) begin
        m_busy = 1'b0;
        if (m_dm) begin
          e_da = 1'b1;
          if (!m_we) m_dm_rd = exp_q[0];
        end else begin
          e_ia = 1'b1;
          m_if_rd = exp_q[0];
        end
        void'(exp_q.pop_front());
      end else if (!m_busy) begin
        g_dm = dm_req && !(GUARD && if_req && m_starve == STARVE_MAX);
        g_if = if_req && !g_dm;
        if (g_dm) begin
          m_dm = 1'b1; m_we = dm_we; m_byte = dm_byte; m_addr = dm_addr; m_wdata = dm_wdata;
          if (if_req && m_starve < STARVE_MAX) m_starve++;
        end else if (g_if) begin
          m_dm = 1'b0; m_we = 1'b0; m_byte = 1'b0; m_addr = if_addr; m_wdata = '0;
          m_starve = 0;
        end
        if (g_dm || g_if) begin
          e_en = 1'b1;
          m_busy = 1'b1;
          m_ack_cyc = cyc + MEM_LAT + 1;
          exp_q.push_back(mem_word(m_addr));
        end
      end
      e_stall = (if_req && !e_ia) || (dm_req && !e_da);
    end
    check("mon mem_en",    32'(mem_en),   32'(e_en));
    check("mon mem_we",    32'(mem_we),   32'(m_we));
    check("mon mem_byte",  32'(mem_byte), 32'(m_byte));
    check("mon mem_addr",  mem_addr,      m_addr);
    check("mon mem_wdata", mem_wdata,     m_wdata);
    check("mon if_ack",    32'(if_ack),   32'(e_ia));
    check("mon dm_ack",    32'(dm_ack),   32'(e_da));
    check("mon if_rdata",  if_rdata,      m_if_rd);
    check("mon dm_rdata",  dm_rdata,      m_dm_rd);
    check("mon stall",     32'(stall),    32'(e_stall));
    if_ack_last = if_ack;
    dm_ack_last = dm_ack;
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic        dm;
    logic        we;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[7];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1 with the arbiter idle.
  task automatic run_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("vec%0d", idx);
    if (v.dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_byte = v.byt; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    @(negedge clk);
    check({s, " issue mem_en"},   32'(mem_en),   32'd1);
    check({s, " issue mem_addr"}, mem_addr,      v.addr);
    check({s, " issue mem_we"},   32'(mem_we),   32'(v.dm & v.we));
    check({s, " issue mem_byte"}, 32'(mem_byte), 32'(v.dm & v.byt));
    if (v.dm) check({s, " issue mem_wdata"}, mem_wdata, v.wdata);
    for (int k = 1; k <= MEM_LAT; k++) begin
      @(negedge clk);
      check({s, " wait acks"},  32'({if_ack, dm_ack}), 32'd0);
      check({s, " wait stall"}, 32'(stall), 32'd1);
    end
    @(negedge clk);
    check({s, " ack"},        32'(v.dm ? dm_ack : if_ack), 32'd1);
    check({s, " rdata"},      v.dm ? dm_rdata : if_rdata, v.exp_rd);
    check({s, " ack stall"},  32'(stall), 32'd0);
    next_cycle();
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_byte = 1'b0;
    next_cycle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_en, n_ack, n_ifack;
    bit got;
    logic grants[$];

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_byte = 1'b0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         32'h2002_0004};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         mem_word(32'h100)};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h0000_0203, 32'h0000_00AB, mem_word(32'h100)};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'hCAFE_BABE, mem_word(32'h100)};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0,         mem_word(32'h44)};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         mem_word(32'hFFFF_FFFC)};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         mem_word(32'h0)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset stall",  32'(stall),  32'd0);
    check("reset mem_en", 32'(mem_en), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single transactions from the vector table.
    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Collision: data first, fetch issued once dm_req has dropped.
    for (int c = 0; c <= 2 * MEM_LAT + 3; c++) begin
      if (c == 0) begin
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; if_req = 1'b1; if_addr = 32'h48;
      end
      if (c == MEM_LAT + 2) dm_req = 1'b0;
      @(negedge clk);
      check("col mem_en", 32'(mem_en), 32'(c == 0 || c == MEM_LAT + 2));
      if (c == 0) check("col data addr", mem_addr, 32'h100);
      if (c == MEM_LAT + 2) check("col fetch addr", mem_addr, 32'h48);
      check("col dm_ack", 32'(dm_ack), 32'(c == MEM_LAT + 1));
      check("col if_ack", 32'(if_ack), 32'(c == 2 * MEM_LAT + 3));
      if (c == 2 * MEM_LAT + 3) check("col if_rdata", if_rdata, mem_word(32'h48));
      next_cycle();
    end
    if_req = 1'b0;
    next_cycle();

    // Back-to-back fetches with if_req held: issue spacing MEM_LAT+2.
    if_addr = 32'h200;
    if_req  = 1'b1;
    for (int c = 0; c < 3 * (MEM_LAT + 2); c++) begin
      @(negedge clk);
      check("b2b mem_en", 32'(mem_en), 32'(c % (MEM_LAT + 2) == 0));
      if (c % (MEM_LAT + 2) == 0)
        check("b2b addr", mem_addr, 32'h200 + 32'(4 * (c / (MEM_LAT + 2))));
      check("b2b if_ack", 32'(if_ack), 32'(c % (MEM_LAT + 2) == MEM_LAT + 1));
      got = if_ack;
      next_cycle();
      if (got) if_addr = if_addr + 32'd4;
    end
    if_req = 1'b0;
    next_cycle();

    // Reset in the WAIT cycle of a fetch, then one fresh transaction.
    if_req = 1'b1; if_addr = 32'h60;
    @(negedge clk);
    check("rst issue", 32'(mem_en), 32'd1);
    next_cycle();
    rst_n = 1'b0;
    if_addr = 32'h80;
    #1;
    check("rst async mem_en",   32'(mem_en),   32'd0);
    check("rst async mem_addr", mem_addr,      32'd0);
    check("rst async stall",    32'(stall),    32'd0);
    check("rst async if_rdata", if_rdata,      32'd0);
    next_cycle();
    rst_n = 1'b1;
    n_en = 0; n_ack = 0;
    for (int c = 0; c < 4 * (MEM_LAT + 2); c++) begin
      @(negedge clk);
      if (mem_en) n_en++;
      got = if_ack;
      if (if_ack) begin
        n_ack++;
        check("rst fresh if_rdata", if_rdata, mem_word(32'h80));
      end
      next_cycle();
      if (got) if_req = 1'b0;
    end
    check("rst issue count", 32'(n_en),  32'd1);
    check("rst ack count",   32'(n_ack), 32'd1);

    // Both requests held: grant order shows priority and starve guard.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500; if_req = 1'b1; if_addr = 32'h600;
    n_ifack = 0;
    grants.delete();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mem_en) grants.push_back(mem_addr == 32'h600);
      if (if_ack) n_ifack++;
      got = (if_ack || dm_ack) && grants.size() >= 6;
      next_cycle();
      if (got) break;
    end
    if_req = 1'b0; dm_req = 1'b0;
    check("starve grant count", 32'(grants.size()), 32'd6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      check($sformatf("starve grant%0d is_fetch", i), 32'(grants[i]), 32'(GUARD && i == STARVE_MAX));
    check("starve if_ack count", 32'(n_ifack), 32'(GUARD ? 1 : 0));
    repeat (2) next_cycle();

    // Randomized traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      if (!if_req || if_ack_last) begin
        if_req  = ($urandom_range(0, 99) < 55);
        if_addr = $urandom() & 32'h0000_FFFC;
      end
      if (!dm_req || dm_ack_last) begin
        dm_req   = ($urandom_range(0, 99) < 45);
        dm_we    = 1'($urandom_range(0, 1));
        dm_byte  = 1'($urandom_range(0, 1));
        dm_addr  = $urandom();
        dm_wdata = $urandom();
      end
      next_cycle();
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (MEM_LAT + 4) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch requester (read-only) and the data-memory requester (load/store word/byte) of the 5-stage MIPS pipeline. Sequences each access over a fixed memory latency, returns read data with a one-cycle ack, and raises a global stall so that the PC, IF_ID and ID_EXE registers hold while any request is outstanding. Data requests take priority over fetch by default, because the MEM-stage instruction is older.

Parameters:
MEM_LAT, 2, cycles from issue (mem_en high) to mem_rdata valid; legal range 1..15
STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced (optional feature only); legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, level, held until if_ack
if_addr  in  32  fetch byte address
if_rdata  out  32  fetched instruction, valid while if_ack=1
if_ack  out  1  one-cycle fetch completion pulse
dm_req  in  1  data request, level, held until dm_ack
dm_we  in  1  1=store, 0=load
dm_byte  in  1  1=byte store, 0=word
dm_addr  in  32  data byte address
dm_wdata  in  32  store data
dm_rdata  out  32  load data, valid while dm_ack=1
dm_ack  out  1  one-cycle data completion pulse
mem_en  out  1  memory access strobe, exactly one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_byte  out  1  byte-store select, qualified by mem_en
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid MEM_LAT cycles after issue
stall  out  1  pipeline hold

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; latency counter 0; owner 0; starve counter 0. An in-flight access is discarded, and no ack is issued for it after reset release.
- FSM states: IDLE, WAIT, RESP.
- IDLE: requests are sampled only in this state.
  - dm_req=1: grant data.
  - else if_req=1: grant fetch.
  - else stay in IDLE.
  - On a grant in cycle T: mem_en=1 combinationally in T, driven from the granted requester's addr, we, byte and wdata (fetch forces we=0, byte=0). Latch the owner, load counter=MEM_LAT, move to WAIT.
- WAIT: mem_en=0; all mem_* outputs except mem_en hold their issued values. Decrement the counter each cycle. In cycle T+MEM_LAT (counter reaches 0), register mem_rdata into the owner's rdata and move to RESP.
- RESP (cycle T+MEM_LAT+1): the owner's ack=1 for exactly one cycle, then return to IDLE. No issue happens in RESP, so a still-high req of the acked requester is never double-issued. The earliest next issue is T+MEM_LAT+2.
- In IDLE a req held high after its ack is treated as a new transaction (the pipeline presents a new PC or address).
- Stores: same timing. dm_ack pulses in RESP; dm_rdata holds its previous value.
- if_rdata and dm_rdata hold their values outside ack cycles.
- stall = (if_req & ~if_ack) | (dm_req & ~dm_ack). It is combinational and 0 in the ack cycle, so the pipeline advances exactly on the ack.
- Simultaneous if_req and dm_req in IDLE: data is granted. Fetch stays pending and is granted at the next IDLE if dm_req is low.
- Request changes during WAIT or RESP are ignored; the latched issue values are used.
- No address alignment checks; the address is passed through unchanged.

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined:
  - A starve counter increments on each data grant made while if_req=1, and clears on every fetch grant.
  - When the counter equals STARVE_MAX and if_req=1 in IDLE, fetch is granted even if dm_req=1. The counter then clears.
  - The counter saturates and never wraps.
- Undefined: strict data priority; the counter logic is absent.

Test Plan:
- Lone fetch, MEM_LAT=2: if_req=1, if_addr=0x0000_0040 at cycle 0 -> mem_en=1, mem_addr=0x40, mem_we=0 in cycle 0; mem_rdata=0x2002_0004 in cycle 2 -> if_ack=1, if_rdata=0x2002_0004 in cycle 3; stall=1 in cycles 0-2, 0 in cycle 3.
- Collision: if_req=dm_req=1 (load 0x100) at cycle 0 -> data issued in cycle 0, dm_ack in cycle 3; fetch issued in cycle 4 (dm_req low), if_ack in cycle 7.
- Byte store: dm_we=1, dm_byte=1, dm_addr=0x203, dm_wdata=0xAB -> mem_en, mem_we and mem_byte =1 for one cycle with those values; dm_ack after MEM_LAT+1 cycles; dm_rdata unchanged.
- Reset mid-access: rst_n=0 in the WAIT cycle of a fetch -> all outputs 0 immediately; after release with if_req=1, a fresh issue occurs and exactly one if_ack is seen.
- MEM_LAT=1 back-to-back fetches with if_req held high -> mem_en in cycles 0, 3, 6; if_ack in cycles 2, 5, 8; never two mem_en within 3 cycles.
- With ARB_STARVE_GUARD_EN, STARVE_MAX=4, both reqs held high -> grant order D,D,D,D,F,D…; without the macro, D only, with if_ack never asserted.
